// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default parameters for the pmem port arbiter
package mem_port_arbiter_pkg;

    localparam int MAX_D_STREAK_DEF = 4;
    localparam int LOCK_TIMEOUT_DEF = 4;
    localparam int LINE_W_DEF       = 128;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_D_LOCK
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// rtl/mem_port_arbiter_mux.sv - combinational routing of the granted cache onto pmem, resp gating
module arb_port_mux
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
) (
    input  arb_state_t        state,
    input  logic              i_mem_read,
    input  lc3b_word          i_mem_address,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  lc3b_word          d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output lc3b_word          pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              i_mem_resp,
    output logic              d_mem_resp
);

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_mem_resp   = 1'b0;
        d_mem_resp   = 1'b0;
        case (state)
            ARB_SERVE_I: begin
                pmem_read    = i_mem_read;
                pmem_address = i_mem_address;
                i_mem_resp   = pmem_resp;
            end
            ARB_SERVE_D: begin
                // A simultaneous read+write is treated as the writeback; the read follows it.
                pmem_write   = d_mem_write;
                pmem_read    = d_mem_read & ~d_mem_write;
                pmem_address = d_mem_address;
                pmem_wdata   = d_mem_wdata;
                d_mem_resp   = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one pmem port between I-cache and D-cache with atomic evict+refill
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int LINE_W       = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_mem_read,
    input  lc3b_word          i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  lc3b_word          d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output lc3b_word          pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TIMEOUT - 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] d_streak, d_streak_nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic          d_req;

    assign d_req = d_mem_read | d_mem_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            d_streak <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            d_streak <= d_streak_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        d_streak_nxt = d_streak;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ARB_IDLE: begin
                if (d_req && i_mem_read) begin
                    // d_streak only grows while I is actually being held off.
                    if (d_streak < STREAK_MAX) begin
                        state_nxt    = ARB_SERVE_D;
                        d_streak_nxt = d_streak + 1'b1;
                    end else begin
                        state_nxt = ARB_SERVE_I;
                    end
                end else if (d_req) begin
                    state_nxt = ARB_SERVE_D;
                end else if (i_mem_read) begin
                    state_nxt = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                if (pmem_resp) begin
                    state_nxt    = ARB_IDLE;
                    d_streak_nxt = '0;
                end
            end
            ARB_SERVE_D: begin
                if (pmem_resp) begin
                    state_nxt    = d_mem_write ? ARB_D_LOCK : ARB_IDLE;
                    lock_cnt_nxt = '0;
                end
            end
            ARB_D_LOCK: begin
                // Hold the port for the refill that normally follows a dirty eviction.
                if (d_req) begin
                    state_nxt = ARB_SERVE_D;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt = ARB_IDLE;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    arb_port_mux #(.LINE_W(LINE_W)) u_mux (
        .state         (state),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_address (d_mem_address),
        .d_mem_wdata   (d_mem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_resp    (d_mem_resp)
    );

    assign i_mem_rdata = pmem_rdata;
    assign d_mem_rdata = pmem_rdata;

    a_i_held: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ARB_SERVE_I) |-> i_mem_read);
    a_d_held: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ARB_SERVE_D) |-> d_req);
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(d_mem_read && d_mem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAXS  = 4;
    localparam int LOCKT = 4;
    localparam int LW    = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_mem_read = 1'b0;
    logic [15:0]   i_mem_address = '0;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read = 1'b0;
    logic          d_mem_write = 1'b0;
    logic [15:0]   d_mem_address = '0;
    logic [LW-1:0] d_mem_wdata = '0;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .LOCK_TIMEOUT(LOCKT), .LINE_W(LW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_address (d_mem_address),
        .d_mem_wdata   (d_mem_wdata),
        .d_mem_rdata   (d_mem_rdata),
        .d_mem_resp    (d_mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            if (pmem_read && pmem_write) begin
                bad++;
                $display("FAIL rw_overlap: read=%0b write=%0b required never both", pmem_read, pmem_write);
            end
            total++;
            if (i_mem_rdata !== pmem_rdata || d_mem_rdata !== pmem_rdata) begin
                bad++;
                $display("FAIL rdata_route: i=%h d=%h required %h", i_mem_rdata, d_mem_rdata, pmem_rdata);
            end
        end
    end

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_grant(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0 || pmem_address !== 16'h0 || pmem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rd=%0b wr=%0b iresp=%0b dresp=%0b addr=%h required all 0",
                     pmem_read, pmem_write, i_mem_resp, d_mem_resp, pmem_address);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        d_mem_read = 1'b1;
        d_mem_address = 16'h8040;
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_comb_grant: pmem_read=%0b required 0", pmem_read);
        end
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h8040) begin
            bad++;
            $display("FAIL reset_pre_grant: rd=%0b addr=%h required 1/8040", pmem_read, pmem_address);
        end
        reset_n = 1'b0;
        d_mem_read = 1'b0;
        #1;
        total++;
        if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0 || pmem_address !== 16'h0) begin
            bad++;
            $display("FAIL reset_abort: rd=%0b wr=%0b addr=%h required 0", pmem_read, pmem_write, pmem_address);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        pmem_resp = 1'b1;
        #1;
        total++;
        if (i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL stray_resp: iresp=%0b dresp=%0b rd=%0b required 0", i_mem_resp, d_mem_resp, pmem_read);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
    endtask

    task automatic test_i_only();
        logic [LW-1:0] line;
        line = {16{8'hA5}};
        @(posedge clk); #1;
        i_mem_read = 1'b1;
        i_mem_address = 16'h1230;
        pmem_rdata = line;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL i_only_latency: pmem_read=%0b required 0 in request cycle", pmem_read);
        end
        @(posedge clk); #2;
        total++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
            bad++;
            $display("FAIL i_only_grant: rd=%0b wr=%0b addr=%h required 1/0/1230", pmem_read, pmem_write, pmem_address);
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0 || i_mem_rdata !== line) begin
            bad++;
            $display("FAIL i_only_resp: iresp=%0b dresp=%0b data=%h required 1/0/%h", i_mem_resp, d_mem_resp, i_mem_rdata, line);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL i_only_release: pmem_read=%0b required 0", pmem_read);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        logic [15:0] ia, da;
        logic [LW-1:0] line;
        ia = 16'($urandom_range(0, 32767));
        da = 16'h8000 | 16'($urandom_range(0, 32767));
        line = rand_line();
        @(posedge clk); #1;
        i_mem_read = 1'b1; i_mem_address = ia;
        d_mem_read = 1'b1; d_mem_address = da;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_address !== da) begin
            bad++;
            $display("FAIL simul_first: addr=%h cyc=%0d required %h", pmem_address, c, da);
        end
        pmem_rdata = line;
        pmem_resp = 1'b1;
        #1;
        total++;
        if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0 || d_mem_rdata !== line) begin
            bad++;
            $display("FAIL simul_d_resp: dresp=%0b iresp=%0b required 1/0", d_mem_resp, i_mem_resp);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_mem_read = 1'b0;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_address !== ia || pmem_read !== 1'b1) begin
            bad++;
            $display("FAIL simul_second: addr=%h cyc=%0d required %h", pmem_address, c, ia);
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0) begin
            bad++;
            $display("FAIL simul_i_resp: iresp=%0b dresp=%0b required 1/0", i_mem_resp, d_mem_resp);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
    endtask

    task automatic test_streak();
        int c;
        bit got_i, exp_i;
        i_mem_read = 1'b1;
        i_mem_address = 16'($urandom_range(0, 32767));
        d_mem_read = 1'b1;
        d_mem_address = 16'h8000 | 16'($urandom_range(0, 32767));
        for (int k = 1; k <= MAXS + 1; k++) begin
            wait_grant(c);
            exp_i = (k == MAXS + 1);
            got_i = (pmem_address == i_mem_address);
            total++;
            if (c < 0 || got_i !== exp_i) begin
                bad++;
                $display("FAIL streak_arb%0d: i_granted=%0b required %0b", k, got_i, exp_i);
            end
            pmem_resp = 1'b1;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (got_i) i_mem_read = 1'b0;
            else d_mem_address = 16'h8000 | 16'($urandom_range(0, 32767));
        end
        d_mem_read = 1'b0;
        if (i_mem_read) begin
            wait_grant(c);
            pmem_resp = 1'b1;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            i_mem_read = 1'b0;
        end
    endtask

    task automatic test_writeback();
        int c;
        logic [LW-1:0] wd;
        logic [15:0] ia;
        wd = rand_line();
        ia = 16'($urandom_range(0, 32767));
        @(posedge clk); #1;
        d_mem_write = 1'b1; d_mem_address = 16'h4000; d_mem_wdata = wd;
        i_mem_read = 1'b1; i_mem_address = ia;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 || pmem_wdata !== wd) begin
            bad++;
            $display("FAIL wb_write: wr=%0b rd=%0b addr=%h required 1/0/4000", pmem_write, pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        #1;
        total++;
        if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0) begin
            bad++;
            $display("FAIL wb_write_resp: dresp=%0b iresp=%0b required 1/0", d_mem_resp, i_mem_resp);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_mem_write = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            bad++;
            $display("FAIL wb_lock_quiet: rd=%0b wr=%0b required 0/0", pmem_read, pmem_write);
        end
        @(posedge clk); #1;
        d_mem_read = 1'b1;
        d_mem_address = 16'h8000;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_read !== 1'b1 || pmem_address !== 16'h8000) begin
            bad++;
            $display("FAIL wb_refill_atomic: rd=%0b addr=%h required 1/8000", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_mem_read = 1'b0;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_address !== ia) begin
            bad++;
            $display("FAIL wb_i_after: addr=%h required %h", pmem_address, ia);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
    endtask

    task automatic test_lock_timeout();
        int c;
        logic [15:0] ia;
        ia = 16'($urandom_range(0, 32767));
        @(posedge clk); #1;
        d_mem_write = 1'b1;
        d_mem_address = 16'h8000 | 16'($urandom_range(0, 32767));
        d_mem_wdata = rand_line();
        i_mem_read = 1'b1; i_mem_address = ia;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_write !== 1'b1) begin
            bad++;
            $display("FAIL lock_write: wr=%0b required 1", pmem_write);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_mem_write = 1'b0;
        wait_grant(c);
        total++;
        if (c !== LOCKT + 2 || pmem_address !== ia) begin
            bad++;
            $display("FAIL lock_timeout: cycles=%0d addr=%h required %0d/%h", c, pmem_address, LOCKT + 2, ia);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c;
        logic [15:0] a1, a2;
        a1 = 16'($urandom_range(0, 32767));
        a2 = a1 ^ 16'h0010;
        @(posedge clk); #1;
        i_mem_read = 1'b1; i_mem_address = a1;
        wait_grant(c);
        total++;
        if (c < 0 || pmem_address !== a1) begin
            bad++;
            $display("FAIL b2b_first: addr=%h required %h", pmem_address, a1);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_address = a2;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap: pmem_read=%0b required 0", pmem_read);
        end
        @(posedge clk); #2;
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== a2) begin
            bad++;
            $display("FAIL b2b_second: rd=%0b addr=%h required 1/%h", pmem_read, pmem_address, a2);
        end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
    endtask

    task automatic test_random();
        bit i_busy, act, own_d, resp_now, need_d, gen, got_d, got_i;
        int d_ph, gap, mcnt, i_wait;
        logic [15:0] act_addr;
        i_busy = 0; act = 0; own_d = 0; resp_now = 0; need_d = 0;
        d_ph = 0; gap = 0; mcnt = 0; i_wait = 0; act_addr = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            gen = (cyc < 700);
            @(posedge clk); #1;
            if (resp_now) begin
                resp_now = 0; pmem_resp = 1'b0; act = 0;
                if (own_d) begin
                    if (d_ph == 1) begin
                        d_mem_write = 1'b0; d_ph = 2; gap = $urandom_range(0, 2); need_d = 1;
                    end else begin
                        d_mem_read = 1'b0; d_ph = 0;
                    end
                end else begin
                    i_mem_read = 1'b0; i_busy = 0;
                end
            end
            if (d_ph == 2) begin
                if (gap == 0) begin
                    d_mem_read = 1'b1;
                    d_mem_address = 16'h8000 | 16'($urandom_range(0, 32767));
                    d_ph = 3;
                end else gap--;
            end else if (d_ph == 0 && gen && $urandom_range(0, 9) < 7) begin
                d_mem_address = 16'h8000 | 16'($urandom_range(0, 32767));
                if ($urandom_range(0, 1) == 1) begin
                    d_mem_write = 1'b1; d_mem_wdata = rand_line(); d_ph = 1;
                end else begin
                    d_mem_read = 1'b1; d_ph = 3;
                end
            end
            if (!i_busy && gen && $urandom_range(0, 9) < 6) begin
                i_busy = 1; i_mem_read = 1'b1; i_wait = 0;
                i_mem_address = 16'($urandom_range(0, 32767));
            end
            if (act) begin
                if (mcnt == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = rand_line(); resp_now = 1;
                end else mcnt--;
            end
            #1;
            total++;
            if (i_mem_resp !== (resp_now && !own_d) || d_mem_resp !== (resp_now && own_d)) begin
                bad++;
                $display("FAIL rnd_resp_gate: iresp=%0b dresp=%0b required %0b/%0b",
                         i_mem_resp, d_mem_resp, resp_now && !own_d, resp_now && own_d);
            end
            if (act) begin
                total++;
                if (!(pmem_read || pmem_write) || pmem_address !== act_addr) begin
                    bad++;
                    $display("FAIL rnd_hold: rd=%0b wr=%0b addr=%h required active at %h", pmem_read, pmem_write, pmem_address, act_addr);
                end
            end else if (pmem_read || pmem_write) begin
                got_d = (d_ph == 1 || d_ph == 3) && pmem_address == d_mem_address && pmem_write == (d_ph == 1);
                got_i = i_busy && pmem_address == i_mem_address && pmem_read && !pmem_write;
                total++;
                if (!got_d && !got_i) begin
                    bad++;
                    $display("FAIL rnd_owner: rd=%0b wr=%0b addr=%h required a pending request", pmem_read, pmem_write, pmem_address);
                end
                if (need_d) begin
                    total++;
                    if (!(got_d && d_ph == 3)) begin
                        bad++;
                        $display("FAIL rnd_atomic: addr=%h required D refill %h", pmem_address, d_mem_address);
                    end
                    need_d = 0;
                end
                if (got_d && d_ph == 1) begin
                    total++;
                    if (pmem_wdata !== d_mem_wdata) begin
                        bad++;
                        $display("FAIL rnd_wdata: got %h required %h", pmem_wdata, d_mem_wdata);
                    end
                end
                if (got_d && i_busy) begin
                    i_wait++;
                    total++;
                    if (i_wait > 2 * MAXS + 2) begin
                        bad++;
                        $display("FAIL rnd_starve: d_grants=%0d required <= %0d", i_wait, 2 * MAXS + 2);
                    end
                end
                if (got_i) i_wait = 0;
                act = 1; own_d = got_d; act_addr = pmem_address;
                mcnt = $urandom_range(0, 2);
            end
        end
        total++;
        if (i_busy || d_ph != 0 || act) begin
            bad++;
            $display("FAIL rnd_drain: i_busy=%0b d_phase=%0d active=%0b required all idle", i_busy, d_ph, act);
        end
        i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; pmem_resp = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_i_only();
        test_simultaneous();
        test_streak();
        test_writeback();
        test_lock_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
